ex3_load_format: RTL and testbench

Registered load-result formatter for the EX3 stage of the integer/FP pipeline. It converts raw L1D load data into its architectural register form:
- plain 64-bit
- FP32→FP64 and FP16→FP64 scalar widening
- packed 2×FP16→2×FP32 and 4×FP8→4×FP16
- 48-bit loads

It also steers texel-block results from an external block-texture decoder. Its output feeds the EX3→WB destination port.

---
 rtl/ex3_load_format_pkg.sv | 44 ++++
 rtl/ex3_load_format_fp_small_widen.sv | 38 +++
 rtl/ex3_load_format.sv | 90 +++++++++
 tb/tb_ex3_load_format.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ex3_load_format_pkg.sv
// Shared definitions for the EX3 load-result formatter: mode encodings,
// the no-write register id and the texture decoder format codes.
`timescale 1ns/1ps
package ex3_load_format_pkg;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'd0,
        MODE_INT64 = 3'd1,
        MODE_S2D   = 3'd2,
        MODE_H2D   = 3'd3,
        MODE_H2S2  = 3'd4,
        MODE_M8H4  = 3'd5,
        MODE_LD48  = 3'd6,
        MODE_TEX   = 3'd7
    } ldMode_e;

    localparam logic [6:0] ZZR = 7'h3F;

    localparam logic [5:0] JX2_UCIX_CONV2_BLKUTX2       = 6'h04;
    localparam logic [5:0] JX2_UCIX_CONV2_RGB30APCK64F  = 6'h0C;
    localparam logic [5:0] JX2_UCIX_CONV2_BLKUTX3L      = 6'h14;
    localparam logic [5:0] JX2_UCIX_CONV2_BLKUTX3H      = 6'h15;
    localparam logic [5:0] JX2_UCIX_CONV2_BLKRGB15F     = 6'h18;
    localparam logic [5:0] JX2_UCIX_CONV2_BLKRGB15A     = 6'h19;
    localparam logic [5:0] JX2_UCIX_CONV2_BLKRGBA32     = 6'h1A;
    localparam logic [5:0] JX2_UCIX_CONV2_RGB32UPCK64FU = 6'h0D;

    // Maps the 3-bit texture descriptor field onto the decoder's format code.
    function automatic logic [5:0] texFmtDecode(input logic [2:0] desc);
        logic [5:0] fmt;
        case (desc)
            3'd0:    fmt = JX2_UCIX_CONV2_BLKUTX2;
            3'd1:    fmt = JX2_UCIX_CONV2_RGB30APCK64F;
            3'd2:    fmt = JX2_UCIX_CONV2_BLKUTX3L;
            3'd3:    fmt = JX2_UCIX_CONV2_BLKUTX3H;
            3'd4:    fmt = JX2_UCIX_CONV2_BLKRGB15F;
            3'd5:    fmt = JX2_UCIX_CONV2_BLKRGB15A;
            3'd6:    fmt = JX2_UCIX_CONV2_BLKRGBA32;
            default: fmt = JX2_UCIX_CONV2_RGB32UPCK64FU;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/ex3_load_format_fp_small_widen.sv
// Widens a small float to a larger one; denormals flush to signed zero and
// the all-ones exponent (inf/NaN) keeps its payload.
`timescale 1ns/1ps
module fp_small_widen #(
    parameter int EW_IN      = 5,
    parameter int MW_IN      = 10,
    parameter int EW_OUT     = 11,
    parameter int MW_OUT     = 52,
    parameter int BIAS_DELTA = 1008
) (
    input  logic [EW_IN+MW_IN:0]   narrow,
    output logic [EW_OUT+MW_OUT:0] wide
);

    localparam logic [EW_OUT-1:0] DELTA = EW_OUT'(BIAS_DELTA);

    logic              sign;
    logic [EW_IN-1:0]  expIn;
    logic [MW_IN-1:0]  manIn;
    logic [EW_OUT-1:0] expBiased;
    logic [MW_OUT-1:0] manOut;

    assign {sign, expIn, manIn} = narrow;
    assign expBiased = EW_OUT'(expIn) + DELTA;
    assign manOut    = {manIn, {(MW_OUT-MW_IN){1'b0}}};

    always_comb begin
        wide = {sign, {(EW_OUT+MW_OUT){1'b0}}};
        if (expIn == '0) begin
            wide = {sign, {(EW_OUT+MW_OUT){1'b0}}};
        end else if (&expIn) begin
            wide = {sign, {EW_OUT{1'b1}}, manOut};
        end else begin
            wide = {sign, expBiased, manOut};
        end
    end

endmodule

// File: rtl/ex3_load_format.sv
// EX3 load-result formatter: converts raw load data to register form and
// registers it, with destination id, toward the WB port.
`timescale 1ns/1ps
module ex3_load_format
    import ex3_load_format_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  mode,
    input  logic        ld48_hi,
    input  logic        ld48_uns,
    input  logic        flush,
    input  logic [6:0]  dst_id,
    input  logic [63:0] mem_a,
    input  logic [2:0]  tex_desc,
    input  logic [3:0]  tex_coord,
    input  logic [63:0] tex_val,
    output logic [5:0]  tex_fmt,
    output logic [3:0]  tex_ix,
    output logic [6:0]  out_id,
    output logic [63:0] out_val,
    output logic        out_held
);

    ldMode_e     opMode;
    logic [63:0] s2dVal;
    logic [63:0] h2dVal;
    logic [63:0] h2sVal;
    logic [63:0] m8hVal;
    logic [63:0] ld48Val;
    logic [63:0] nextVal;

    assign opMode  = ldMode_e'(mode);
    assign tex_fmt = texFmtDecode(tex_desc);
    assign tex_ix  = tex_coord;

    fp_small_widen #(.EW_IN(8), .MW_IN(23), .EW_OUT(11), .MW_OUT(52), .BIAS_DELTA(896))
        uS2D (.narrow(mem_a[31:0]), .wide(s2dVal));

    fp_small_widen #(.EW_IN(5), .MW_IN(10), .EW_OUT(11), .MW_OUT(52), .BIAS_DELTA(1008))
        uH2D (.narrow(mem_a[15:0]), .wide(h2dVal));

    for (genvar i = 0; i < 2; i++) begin : genH2S
        fp_small_widen #(.EW_IN(5), .MW_IN(10), .EW_OUT(8), .MW_OUT(23), .BIAS_DELTA(112))
            uH2S (.narrow(mem_a[16*i +: 16]), .wide(h2sVal[32*i +: 32]));
    end

    // Each FP8 lane widens to 12 bits, left-aligned in its 16-bit slot.
    for (genvar i = 0; i < 4; i++) begin : genM8H
        logic [11:0] lane12;
        fp_small_widen #(.EW_IN(4), .MW_IN(3), .EW_OUT(5), .MW_OUT(6), .BIAS_DELTA(8))
            uM8H (.narrow(mem_a[8*i +: 8]), .wide(lane12));
        assign m8hVal[16*i +: 16] = {lane12, 4'h0};
    end

    assign ld48Val = ld48_hi ? {mem_a[47:0], 16'h0}
                             : {{16{mem_a[47] & ~ld48_uns}}, mem_a[47:0]};

    always_comb begin
        nextVal = '0;
        case (opMode)
            MODE_INT64: nextVal = mem_a;
            MODE_S2D:   nextVal = s2dVal;
            MODE_H2D:   nextVal = h2dVal;
            MODE_H2S2:  nextVal = h2sVal;
            MODE_M8H4:  nextVal = m8hVal;
            MODE_LD48:  nextVal = ld48Val;
            MODE_TEX:   nextVal = tex_val;
            default:    nextVal = '0;
        endcase
    end

    // Reset beats flush, and flush beats any op presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_id   <= ZZR;
            out_val  <= '0;
            out_held <= 1'b0;
        end else if (opMode == MODE_NONE || flush) begin
            out_id   <= ZZR;
            out_val  <= '0;
            out_held <= 1'b0;
        end else begin
            out_id   <= dst_id;
            out_val  <= nextVal;
            out_held <= (opMode != MODE_INT64);
        end
    end

endmodule

// File: tb/tb_ex3_load_format.sv
// Randomized self-checking bench for ex3_load_format against an IEEE-style
// field-level reference model.
`timescale 1ns/1ps
module tb_ex3_load_format;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mode = '0;
    logic        ld48_hi = 1'b0;
    logic        ld48_uns = 1'b0;
    logic        flush = 1'b0;
    logic [6:0]  dst_id = '0;
    logic [63:0] mem_a = '0;
    logic [2:0]  tex_desc = '0;
    logic [3:0]  tex_coord = '0;
    logic [63:0] tex_val = '0;
    logic [5:0]  tex_fmt;
    logic [3:0]  tex_ix;
    logic [6:0]  out_id;
    logic [63:0] out_val;
    logic        out_held;

    int testsRun = 0;
    int testsFailed = 0;

    logic [5:0] texTable [8] = '{6'h04, 6'h0C, 6'h14, 6'h15, 6'h18, 6'h19, 6'h1A, 6'h0D};

    ex3_load_format dut (
        .clock(clock), .reset(reset), .mode(mode), .ld48_hi(ld48_hi),
        .ld48_uns(ld48_uns), .flush(flush), .dst_id(dst_id), .mem_a(mem_a),
        .tex_desc(tex_desc), .tex_coord(tex_coord), .tex_val(tex_val),
        .tex_fmt(tex_fmt), .tex_ix(tex_ix), .out_id(out_id),
        .out_val(out_val), .out_held(out_held)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Converts a float with eIn/mIn field widths to eOut/mOut using true IEEE biases.
    function automatic logic [63:0] refWiden(input logic [63:0] bits, input int eIn,
                                             input int mIn, input int eOut, input int mOut);
        logic [63:0] s, e, m, eMaxIn, eMaxOut, biasIn, biasOut, signPart;
        s        = (bits >> (eIn + mIn)) & 64'd1;
        e        = (bits >> mIn) & ((64'd1 << eIn) - 1);
        m        = bits & ((64'd1 << mIn) - 1);
        eMaxIn   = (64'd1 << eIn) - 1;
        eMaxOut  = (64'd1 << eOut) - 1;
        biasIn   = (64'd1 << (eIn - 1)) - 1;
        biasOut  = (64'd1 << (eOut - 1)) - 1;
        signPart = s << (eOut + mOut);
        if (e == 0) return signPart;
        if (e == eMaxIn) return signPart | (eMaxOut << mOut) | (m << (mOut - mIn));
        return signPart | ((e - biasIn + biasOut) << mOut) | (m << (mOut - mIn));
    endfunction

    function automatic logic [63:0] refValue(input int md, input logic hi, input logic uns,
                                             input logic [63:0] a, input logic [63:0] tv);
        logic [63:0] r;
        r = 64'd0;
        case (md)
            1: r = a;
            2: r = refWiden(a & 64'hFFFF_FFFF, 8, 23, 11, 52);
            3: r = refWiden(a & 64'hFFFF, 5, 10, 11, 52);
            4: for (int i = 0; i < 2; i++)
                   r = r | (refWiden((a >> (16 * i)) & 64'hFFFF, 5, 10, 8, 23) << (32 * i));
            5: for (int i = 0; i < 4; i++)
                   r = r | ((refWiden((a >> (8 * i)) & 64'hFF, 4, 3, 5, 6) << 4) << (16 * i));
            6: begin
                   if (hi) r = (a & 64'h0000_FFFF_FFFF_FFFF) << 16;
                   else begin
                       r = a & 64'h0000_FFFF_FFFF_FFFF;
                       if (a[47] && !uns) r = r | 64'hFFFF_0000_0000_0000;
                   end
               end
            7: r = tv;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Drives one op, checks the combinational texture outputs, then the registered result.
    task automatic applyStimulus(input int md, input logic hi, input logic uns, input logic fl,
                                 input logic [6:0] dst, input logic [63:0] a,
                                 input logic [2:0] desc, input logic [3:0] coord,
                                 input logic [63:0] tv);
        logic [6:0]  expId;
        logic [63:0] expVal;
        logic        expHeld;
        mode = 3'(md); ld48_hi = hi; ld48_uns = uns; flush = fl; dst_id = dst;
        mem_a = a; tex_desc = desc; tex_coord = coord; tex_val = tv;
        #1;
        checkOutput("tex_fmt", 64'(tex_fmt), 64'(texTable[desc]));
        checkOutput("tex_ix", 64'(tex_ix), 64'(coord));
        if (reset || fl || md == 0) begin
            expId = 7'h3F; expVal = 64'd0; expHeld = 1'b0;
        end else begin
            expId = dst; expVal = refValue(md, hi, uns, a, tv); expHeld = (md >= 2);
        end
        @(posedge clock);
        #1;
        checkOutput("out_id", 64'(out_id), 64'(expId));
        checkOutput("out_val", out_val, expVal);
        checkOutput("out_held", 64'(out_held), 64'(expHeld));
    endtask

    // Pushes random exponent fields to zero or all-ones so specials get exercised.
    function automatic logic [63:0] biasSpecials(input int md, input logic [63:0] a);
        logic [63:0] r;
        int pick;
        r = a;
        pick = $urandom_range(0, 5);
        case (md)
            2: if (pick == 0) r[30:23] = 8'h00; else if (pick == 1) r[30:23] = 8'hFF;
            3, 4: begin
                if (pick == 0) r[14:10] = 5'h00; else if (pick == 1) r[14:10] = 5'h1F;
                if (pick == 2) r[30:26] = 5'h1F; else if (pick == 3) r[30:26] = 5'h00;
            end
            default: r = a;
        endcase
        return r;
    endfunction

    initial begin
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_id", 64'(out_id), 64'h3F);
        checkOutput("reset_val", out_val, 64'd0);
        checkOutput("reset_held", 64'(out_held), 64'd0);
        reset = 1'b0;

        applyStimulus(1, 0, 0, 0, 7'd5, 64'h0123456789ABCDEF, 3'd0, 4'd0, 64'd0);
        checkOutput("int64_dir", out_val, 64'h0123456789ABCDEF);
        applyStimulus(2, 0, 0, 0, 7'd9, 64'h3F800000, 3'd1, 4'd1, 64'd0);
        checkOutput("s2d_dir", out_val, 64'h3FF0000000000000);
        applyStimulus(3, 0, 0, 0, 7'd10, 64'hC000, 3'd2, 4'd2, 64'd0);
        checkOutput("h2d_dir", out_val, 64'hC000000000000000);
        applyStimulus(4, 0, 0, 0, 7'd11, 64'h3C007C00, 3'd3, 4'd3, 64'd0);
        checkOutput("h2s_dir", out_val, 64'h3F800000_7F800000);
        applyStimulus(5, 0, 0, 0, 7'd12, 64'h3800B840, 3'd4, 4'd4, 64'd0);
        checkOutput("m8h_dir", out_val, 64'h3C00_0000_BC00_4000);
        applyStimulus(6, 0, 0, 0, 7'd13, 64'h8000_0000_0001, 3'd5, 4'd5, 64'd0);
        checkOutput("ld48_sx", out_val, 64'hFFFF800000000001);
        applyStimulus(6, 0, 1, 0, 7'd13, 64'h8000_0000_0001, 3'd5, 4'd5, 64'd0);
        checkOutput("ld48_zx", out_val, 64'h0000800000000001);
        applyStimulus(6, 1, 0, 0, 7'd13, 64'h8000_0000_0001, 3'd5, 4'd5, 64'd0);
        checkOutput("ld48_hi", out_val, 64'h8000000000010000);
        applyStimulus(7, 0, 0, 0, 7'd14, 64'd0, 3'd6, 4'd9, 64'hDEADBEEFCAFEF00D);
        checkOutput("tex_dir", out_val, 64'hDEADBEEFCAFEF00D);
        applyStimulus(1, 0, 0, 1, 7'd15, 64'h1234, 3'd7, 4'd0, 64'd0);
        checkOutput("flush_dir", 64'(out_id), 64'h3F);

        for (int n = 0; n < 400; n++) begin
            int md;
            logic [63:0] a;
            md = $urandom_range(0, 7);
            a  = biasSpecials(md, {$urandom, $urandom});
            applyStimulus(md, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                          7'($urandom), a, 3'($urandom), 4'($urandom),
                          {$urandom, $urandom});
            if (n == 200) begin
                reset = 1'b1;
                applyStimulus(1, 0, 0, 0, 7'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 4'd0, 64'd0);
                checkOutput("reset_mid_id", 64'(out_id), 64'h3F);
                checkOutput("reset_mid_val", out_val, 64'd0);
                reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
